// File: rtl/kf8237_scalable_address_count_registers_if.sv
// CPU/command-side bundle of the KF8237 address/count register file.
// Handshake: strobes are 1-cycle pulses sampled on the falling clock edge; selects are levels; no back-pressure.
interface kf8237_scalable_address_count_registers_if #(
   parameter int CHANNELS      = 4,
   parameter int ADDRESS_WIDTH = 16,
   parameter int COUNT_WIDTH   = 16
);
   localparam int MAX_W     = (ADDRESS_WIDTH > COUNT_WIDTH) ? ADDRESS_WIDTH : COUNT_WIDTH;
   localparam int REG_BYTES = (MAX_W + 7) / 8;
   localparam int BP_W      = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;

   logic [7:0]               internal_data_bus;
   logic [7:0]               read_data;
   logic [CHANNELS-1:0]      write_address;
   logic [CHANNELS-1:0]      write_count;
   logic [CHANNELS-1:0]      read_address;
   logic [CHANNELS-1:0]      read_count;
   logic                     read_strobe;
   logic                     clear_byte_pointer;
   logic                     master_clear;
   logic [CHANNELS-1:0]      channel_select;
   logic                     initialize_current_register;
   logic                     next_word;
   logic                     decrement_address_config;
   logic                     address_hold_config;
   logic                     autoinitialize_config;
   logic [BP_W-1:0]          byte_pointer;
   logic [ADDRESS_WIDTH-1:0] transfer_address;
   logic                     terminal_count;

   modport slave (
      input  internal_data_bus, write_address, write_count, read_address, read_count,
             read_strobe, clear_byte_pointer, master_clear, channel_select,
             initialize_current_register, next_word, decrement_address_config,
             address_hold_config, autoinitialize_config,
      output read_data, byte_pointer, transfer_address, terminal_count
   );

   modport master (
      output internal_data_bus, write_address, write_count, read_address, read_count,
             read_strobe, clear_byte_pointer, master_clear, channel_select,
             initialize_current_register, next_word, decrement_address_config,
             address_hold_config, autoinitialize_config,
      input  read_data, byte_pointer, transfer_address, terminal_count
   );
endinterface

// File: rtl/kf8237_scalable_address_count_registers.sv
// N-channel base/current address and word-count registers with byte-serial CPU access,
// autoinitialize reload and a registered terminal-count pulse. State changes on the falling clock edge.
module kf8237_scalable_address_count_registers #(
   parameter int CHANNELS      = 4,
   parameter int ADDRESS_WIDTH = 16,
   parameter int COUNT_WIDTH   = 16
) (
   input logic clock,
   input logic reset,
   kf8237_scalable_address_count_registers_if.slave bus
);
   localparam int MAX_W     = (ADDRESS_WIDTH > COUNT_WIDTH) ? ADDRESS_WIDTH : COUNT_WIDTH;
   localparam int REG_BYTES = (MAX_W + 7) / 8;
   localparam int BP_W      = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;
   localparam int BUS_W     = REG_BYTES * 8;
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [ADDRESS_WIDTH-1:0] r_base_addr [CHANNELS];
   logic [ADDRESS_WIDTH-1:0] r_cur_addr  [CHANNELS];
   logic [COUNT_WIDTH-1:0]   r_base_cnt  [CHANNELS];
   logic [COUNT_WIDTH-1:0]   r_cur_cnt   [CHANNELS];
   logic [BP_W-1:0]          r_byte_ptr;
   logic                     r_tc;

   logic [ADDRESS_WIDTH-1:0] w_base_addr_nx [CHANNELS];
   logic [ADDRESS_WIDTH-1:0] w_cur_addr_nx  [CHANNELS];
   logic [COUNT_WIDTH-1:0]   w_base_cnt_nx  [CHANNELS];
   logic [COUNT_WIDTH-1:0]   w_cur_cnt_nx   [CHANNELS];
   logic [BP_W-1:0]          w_byte_ptr_nx;
   logic                     w_tc_nx;

   logic [CH_W-1:0]  w_wa_idx, w_wc_idx, w_ra_idx, w_rc_idx, w_sel_idx;
   logic             w_wa_any, w_wc_any, w_sel_any;
   logic [BUS_W-1:0] w_rd_word;

   // Multi-hot selects resolve to the lowest set index.
   function automatic logic [CH_W-1:0] f_lowest(input logic [CHANNELS-1:0] v);
      logic [CH_W-1:0] idx;
      idx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (v[i]) idx = CH_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [ADDRESS_WIDTH-1:0] f_put_addr(input logic [ADDRESS_WIDTH-1:0] old,
                                                           input logic [BP_W-1:0] idx,
                                                           input logic [7:0] b);
      logic [BUS_W-1:0] w;
      w = BUS_W'(old);
      w[{idx, 3'b000} +: 8] = b;
      return w[ADDRESS_WIDTH-1:0];
   endfunction

   function automatic logic [COUNT_WIDTH-1:0] f_put_cnt(input logic [COUNT_WIDTH-1:0] old,
                                                        input logic [BP_W-1:0] idx,
                                                        input logic [7:0] b);
      logic [BUS_W-1:0] w;
      w = BUS_W'(old);
      w[{idx, 3'b000} +: 8] = b;
      return w[COUNT_WIDTH-1:0];
   endfunction

   assign w_wa_idx  = f_lowest(bus.write_address);
   assign w_wc_idx  = f_lowest(bus.write_count);
   assign w_ra_idx  = f_lowest(bus.read_address);
   assign w_rc_idx  = f_lowest(bus.read_count);
   assign w_sel_idx = f_lowest(bus.channel_select);
   assign w_wa_any  = |bus.write_address;
   assign w_wc_any  = |bus.write_count;
   assign w_sel_any = |bus.channel_select;

   always_comb begin
      w_byte_ptr_nx = r_byte_ptr;
      if (bus.master_clear || bus.clear_byte_pointer) begin
         w_byte_ptr_nx = '0;
      end else if (w_wa_any || w_wc_any || bus.read_strobe) begin
         w_byte_ptr_nx = (r_byte_ptr == BP_W'(REG_BYTES - 1)) ? '0 : r_byte_ptr + BP_W'(1);
      end
   end

   // A CPU write to a channel blocks initialize/next_word on that channel for the cycle.
   always_comb begin
      w_tc_nx = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_base_addr_nx[i] = r_base_addr[i];
         w_cur_addr_nx[i]  = r_cur_addr[i];
         w_base_cnt_nx[i]  = r_base_cnt[i];
         w_cur_cnt_nx[i]   = r_cur_cnt[i];
         if (bus.master_clear) begin
            w_base_addr_nx[i] = '0;
            w_cur_addr_nx[i]  = '0;
            w_base_cnt_nx[i]  = '0;
            w_cur_cnt_nx[i]   = '0;
         end else if ((w_wa_any && w_wa_idx == CH_W'(i)) || (w_wc_any && w_wc_idx == CH_W'(i))) begin
            if (w_wa_any && w_wa_idx == CH_W'(i)) begin
               w_base_addr_nx[i] = f_put_addr(r_base_addr[i], r_byte_ptr, bus.internal_data_bus);
               w_cur_addr_nx[i]  = f_put_addr(r_cur_addr[i], r_byte_ptr, bus.internal_data_bus);
            end
            if (w_wc_any && w_wc_idx == CH_W'(i)) begin
               w_base_cnt_nx[i] = f_put_cnt(r_base_cnt[i], r_byte_ptr, bus.internal_data_bus);
               w_cur_cnt_nx[i]  = f_put_cnt(r_cur_cnt[i], r_byte_ptr, bus.internal_data_bus);
            end
         end else if (w_sel_any && w_sel_idx == CH_W'(i)) begin
            if (bus.initialize_current_register) begin
               w_cur_addr_nx[i] = r_base_addr[i];
               w_cur_cnt_nx[i]  = r_base_cnt[i];
            end else if (bus.next_word) begin
               w_tc_nx = (r_cur_cnt[i] == '0);
               if (r_cur_cnt[i] == '0 && bus.autoinitialize_config) begin
                  w_cur_addr_nx[i] = r_base_addr[i];
                  w_cur_cnt_nx[i]  = r_base_cnt[i];
               end else begin
                  w_cur_cnt_nx[i] = r_cur_cnt[i] - COUNT_WIDTH'(1);
                  if (!bus.address_hold_config) begin
                     w_cur_addr_nx[i] = bus.decrement_address_config ?
                                        r_cur_addr[i] - ADDRESS_WIDTH'(1) :
                                        r_cur_addr[i] + ADDRESS_WIDTH'(1);
                  end
               end
            end
         end
      end
   end

   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_base_addr[i] <= '0;
            r_cur_addr[i]  <= '0;
            r_base_cnt[i]  <= '0;
            r_cur_cnt[i]   <= '0;
         end
         r_byte_ptr <= '0;
         r_tc       <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_base_addr[i] <= w_base_addr_nx[i];
            r_cur_addr[i]  <= w_cur_addr_nx[i];
            r_base_cnt[i]  <= w_base_cnt_nx[i];
            r_cur_cnt[i]   <= w_cur_cnt_nx[i];
         end
         r_byte_ptr <= w_byte_ptr_nx;
         r_tc       <= w_tc_nx;
      end
   end

   // read_address outranks read_count; bytes above a register's width read as zero.
   always_comb begin
      w_rd_word = '0;
      if (|bus.read_address) begin
         w_rd_word = BUS_W'(r_cur_addr[w_ra_idx]);
      end else if (|bus.read_count) begin
         w_rd_word = BUS_W'(r_cur_cnt[w_rc_idx]);
      end
   end

   assign bus.read_data        = w_rd_word[{r_byte_ptr, 3'b000} +: 8];
   assign bus.byte_pointer     = r_byte_ptr;
   assign bus.transfer_address = w_sel_any ? r_cur_addr[w_sel_idx] : '0;
   assign bus.terminal_count   = r_tc;
endmodule

// File: tb/tb_kf8237_scalable_address_count_registers.sv
// Directed vector bench for the KF8237 address/count register file (6 channels, 24-bit address, 16-bit count).
module tb_kf8237_scalable_address_count_registers;
   localparam int CH = 6;
   localparam int AW = 24;
   localparam int CW = 16;

   localparam logic [7:0] F_RS   = 8'h80;
   localparam logic [7:0] F_CBP  = 8'h40;
   localparam logic [7:0] F_MC   = 8'h20;
   localparam logic [7:0] F_INIT = 8'h10;
   localparam logic [7:0] F_NW   = 8'h08;
   localparam logic [7:0] F_DEC  = 8'h04;
   localparam logic [7:0] F_HOLD = 8'h02;
   localparam logic [7:0] F_AUTO = 8'h01;

   localparam logic [5:0] C0 = 6'b000000;
   localparam logic [5:0] C1 = 6'b000010;
   localparam logic [5:0] C2 = 6'b000100;
   localparam logic [5:0] C3 = 6'b001000;
   localparam logic [5:0] C5 = 6'b100000;

   // exp_rd is sampled before the falling edge (uses pre-edge byte pointer); the rest after it.
   typedef struct {
      string       name;
      logic [5:0]  wa, wc, ra, rc, cs;
      logic [7:0]  data, flags, exp_rd;
      logic [1:0]  exp_bp;
      logic [23:0] exp_ta;
      logic        exp_tc;
   } vec_t;

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   vec_t vecs[$];

   kf8237_scalable_address_count_registers_if #(.CHANNELS(CH), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) bus_if ();

   kf8237_scalable_address_count_registers #(.CHANNELS(CH), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(input string n, input logic [5:0] wa, wc, ra, rc, cs,
                               input logic [7:0] d, f, erd, input logic [1:0] ebp,
                               input logic [23:0] eta, input logic etc);
      vec_t v;
      v.name = n; v.wa = wa; v.wc = wc; v.ra = ra; v.rc = rc; v.cs = cs;
      v.data = d; v.flags = f; v.exp_rd = erd; v.exp_bp = ebp; v.exp_ta = eta; v.exp_tc = etc;
      return v;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus_if.write_address               = v.wa;
      bus_if.write_count                 = v.wc;
      bus_if.read_address                = v.ra;
      bus_if.read_count                  = v.rc;
      bus_if.channel_select              = v.cs;
      bus_if.internal_data_bus           = v.data;
      bus_if.read_strobe                 = v.flags[7];
      bus_if.clear_byte_pointer          = v.flags[6];
      bus_if.master_clear                = v.flags[5];
      bus_if.initialize_current_register = v.flags[4];
      bus_if.next_word                   = v.flags[3];
      bus_if.decrement_address_config    = v.flags[2];
      bus_if.address_hold_config         = v.flags[1];
      bus_if.autoinitialize_config       = v.flags[0];
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // Test 1: ch5 address written byte-serially, then read back.
      vecs.push_back(mk("cbp",      C0, C0, C0, C0, C0, 8'h00, F_CBP, 8'h00, 2'd0, 24'h0, 1'b0));
      vecs.push_back(mk("wa5_b0",   C5, C0, C0, C0, C0, 8'h56, 8'h00, 8'h00, 2'd1, 24'h0, 1'b0));
      vecs.push_back(mk("wa5_b1",   C5, C0, C0, C0, C0, 8'h34, 8'h00, 8'h00, 2'd2, 24'h0, 1'b0));
      vecs.push_back(mk("wa5_b2",   C5, C0, C0, C0, C5, 8'h12, 8'h00, 8'h00, 2'd0, 24'h123456, 1'b0));
      vecs.push_back(mk("rd5_b0",   C0, C0, C5, C0, C0, 8'h00, F_RS,  8'h56, 2'd1, 24'h0, 1'b0));
      vecs.push_back(mk("rd5_b1",   C0, C0, C5, C0, C0, 8'h00, F_RS,  8'h34, 2'd2, 24'h0, 1'b0));
      vecs.push_back(mk("rd5_b2",   C0, C0, C5, C0, C0, 8'h00, F_RS,  8'h12, 2'd0, 24'h0, 1'b0));
      // Test 2: ch2 count 2, address 0x10, incrementing, no autoinit.
      vecs.push_back(mk("wc2_b0",   C0, C2, C0, C0, C0, 8'h02, 8'h00, 8'h00, 2'd1, 24'h0, 1'b0));
      vecs.push_back(mk("wc2_b1",   C0, C2, C0, C0, C0, 8'h00, 8'h00, 8'h00, 2'd2, 24'h0, 1'b0));
      vecs.push_back(mk("wc2_b2",   C0, C2, C0, C0, C0, 8'h00, 8'h00, 8'h00, 2'd0, 24'h0, 1'b0));
      vecs.push_back(mk("wa2_b0",   C2, C0, C0, C0, C0, 8'h10, 8'h00, 8'h00, 2'd1, 24'h0, 1'b0));
      vecs.push_back(mk("wa2_b1",   C2, C0, C0, C0, C0, 8'h00, 8'h00, 8'h00, 2'd2, 24'h0, 1'b0));
      vecs.push_back(mk("wa2_b2",   C2, C0, C0, C0, C2, 8'h00, 8'h00, 8'h00, 2'd0, 24'h10, 1'b0));
      vecs.push_back(mk("nw1",      C0, C0, C0, C2, C2, 8'h00, F_NW,  8'h02, 2'd0, 24'h11, 1'b0));
      vecs.push_back(mk("nw2",      C0, C0, C0, C2, C2, 8'h00, F_NW,  8'h01, 2'd0, 24'h12, 1'b0));
      vecs.push_back(mk("nw3",      C0, C0, C0, C2, C2, 8'h00, F_NW,  8'h00, 2'd0, 24'h13, 1'b1));
      vecs.push_back(mk("cnt_b0",   C0, C0, C0, C2, C2, 8'h00, F_RS,  8'hFF, 2'd1, 24'h13, 1'b0));
      vecs.push_back(mk("cnt_b1",   C0, C0, C0, C2, C2, 8'h00, F_RS,  8'hFF, 2'd2, 24'h13, 1'b0));
      vecs.push_back(mk("cnt_b2",   C0, C0, C0, C2, C2, 8'h00, F_RS,  8'h00, 2'd0, 24'h13, 1'b0));
      // Test 3: reload current from base, then autoinitialize on terminal count.
      vecs.push_back(mk("init2",    C0, C0, C0, C0, C2, 8'h00, F_INIT, 8'h00, 2'd0, 24'h10, 1'b0));
      vecs.push_back(mk("nwa1",     C0, C0, C0, C2, C2, 8'h00, F_NW|F_AUTO, 8'h02, 2'd0, 24'h11, 1'b0));
      vecs.push_back(mk("nwa2",     C0, C0, C0, C2, C2, 8'h00, F_NW|F_AUTO, 8'h01, 2'd0, 24'h12, 1'b0));
      vecs.push_back(mk("nwa3",     C0, C0, C0, C2, C2, 8'h00, F_NW|F_AUTO, 8'h00, 2'd0, 24'h10, 1'b1));
      vecs.push_back(mk("nwa4",     C0, C0, C0, C2, C2, 8'h00, F_NW|F_AUTO, 8'h02, 2'd0, 24'h11, 1'b0));
      vecs.push_back(mk("idle2",    C0, C0, C0, C2, C2, 8'h00, 8'h00, 8'h01, 2'd0, 24'h11, 1'b0));
      // Test 4: decrement wraps 0 -> all-ones; address hold.
      vecs.push_back(mk("nwdec",    C0, C0, C3, C0, C3, 8'h00, F_NW|F_DEC, 8'h00, 2'd0, 24'hFFFFFF, 1'b1));
      vecs.push_back(mk("nwhold",   C0, C0, C0, C3, C3, 8'h00, F_NW|F_DEC|F_HOLD, 8'hFF, 2'd0, 24'hFFFFFF, 1'b0));
      vecs.push_back(mk("idle3",    C0, C0, C0, C3, C3, 8'h00, 8'h00, 8'hFE, 2'd0, 24'hFFFFFF, 1'b0));
      vecs.push_back(mk("rd_prio",  C0, C0, C5, C3, C0, 8'h00, 8'h00, 8'h56, 2'd0, 24'h0, 1'b0));
      vecs.push_back(mk("rc_low",   C0, C0, C0, 6'b001100, C0, 8'h00, 8'h00, 8'h01, 2'd0, 24'h0, 1'b0));
      vecs.push_back(mk("ra_low",   C0, C0, 6'b100100, C0, C0, 8'h00, 8'h00, 8'h11, 2'd0, 24'h0, 1'b0));
      // Test 5: CPU write beats next_word; master_clear.
      vecs.push_back(mk("wr_vs_nw", C0, C2, C0, C0, C2, 8'h40, F_NW, 8'h00, 2'd1, 24'h11, 1'b0));
      vecs.push_back(mk("cbp2",     C0, C0, C0, C2, C2, 8'h00, F_CBP, 8'h00, 2'd0, 24'h11, 1'b0));
      vecs.push_back(mk("cnt40",    C0, C0, C0, C2, C0, 8'h00, 8'h00, 8'h40, 2'd0, 24'h0, 1'b0));
      vecs.push_back(mk("rs_nosel", C0, C0, C0, C0, C0, 8'h00, F_RS,  8'h00, 2'd1, 24'h0, 1'b0));
      vecs.push_back(mk("mclr",     C0, C0, C0, C3, C3, 8'h00, F_MC,  8'hFF, 2'd0, 24'h0, 1'b0));
      vecs.push_back(mk("post_mc",  C0, C0, C5, C3, C5, 8'h00, 8'h00, 8'h00, 2'd0, 24'h0, 1'b0));
      // Test 6: multi-hot write strobe hits the lowest channel only.
      vecs.push_back(mk("wa_multi", 6'b001010, C0, C0, C0, C0, 8'hAB, 8'h00, 8'h00, 2'd1, 24'h0, 1'b0));
      vecs.push_back(mk("cbp3",     C0, C0, C1, C0, C1, 8'h00, F_CBP, 8'h00, 2'd0, 24'hAB, 1'b0));
      vecs.push_back(mk("ch3_clr",  C0, C0, C3, C0, C3, 8'h00, 8'h00, 8'h00, 2'd0, 24'h0, 1'b0));
      vecs.push_back(mk("ch1_rd",   C0, C0, C1, C0, C0, 8'h00, 8'h00, 8'hAB, 2'd0, 24'h0, 1'b0));
      vecs.push_back(mk("nw_nosel", C0, C0, C0, C0, C0, 8'h00, F_NW,  8'h00, 2'd0, 24'h0, 1'b0));
      vecs.push_back(mk("ch1_hold", C0, C0, C0, C0, C1, 8'h00, 8'h00, 8'h00, 2'd0, 24'hAB, 1'b0));

      // Reset state
      drive(mk("rst", C0, C0, C0, C0, C5, 8'h00, 8'h00, 8'h00, 2'd0, 24'h0, 1'b0));
      reset = 1'b1;
      #3;
      chk("rst.rd", 32'(bus_if.read_data), 32'h0);
      chk("rst.bp", 32'(bus_if.byte_pointer), 32'h0);
      chk("rst.ta", 32'(bus_if.transfer_address), 32'h0);
      chk("rst.tc", 32'(bus_if.terminal_count), 32'h0);
      #9;
      reset = 1'b0;

      foreach (vecs[k]) begin
         drive(vecs[k]);
         #1;
         chk($sformatf("%s.rd", vecs[k].name), 32'(bus_if.read_data), 32'(vecs[k].exp_rd));
         tick();
         chk($sformatf("%s.bp", vecs[k].name), 32'(bus_if.byte_pointer), 32'(vecs[k].exp_bp));
         chk($sformatf("%s.ta", vecs[k].name), 32'(bus_if.transfer_address), 32'(vecs[k].exp_ta));
         chk($sformatf("%s.tc", vecs[k].name), 32'(bus_if.terminal_count), 32'(vecs[k].exp_tc));
      end

      // Reset while a terminal-count pulse is pending: everything clears immediately.
      drive(mk("mc2", C0, C0, C0, C0, C0, 8'h00, F_MC, 8'h00, 2'd0, 24'h0, 1'b0));
      tick();
      drive(mk("tcnw", C0, C0, C0, C0, C2, 8'h00, F_NW, 8'h00, 2'd0, 24'h0, 1'b0));
      tick();
      chk("rstmid.tc_before", 32'(bus_if.terminal_count), 32'h1);
      chk("rstmid.ta_before", 32'(bus_if.transfer_address), 32'h1);
      drive(mk("idle", C0, C0, C0, C0, C2, 8'h00, 8'h00, 8'h00, 2'd0, 24'h0, 1'b0));
      #1;
      reset = 1'b1;
      #1;
      chk("rstmid.tc", 32'(bus_if.terminal_count), 32'h0);
      chk("rstmid.ta", 32'(bus_if.transfer_address), 32'h0);
      tick();
      reset = 1'b0;
      tick();
      chk("rstmid.tc_after", 32'(bus_if.terminal_count), 32'h0);
      chk("rstmid.ta_after", 32'(bus_if.transfer_address), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/kf8237_scalable_address_count_registers.md
Name: kf8237_scalable_address_count_registers

Overview:
Parametrised address/word-count register file for the KF8237 DMA core. It generalises the 4-channel, 16-bit register set to N channels and configurable address and count widths, with byte-serial CPU access through a multi-state byte pointer. It adds per-transfer address-hold, autoinitialize reload on terminal count, and a registered terminal-count pulse. It sits between the bus/command decoder and the timing/priority logic.

Parameters:
CHANNELS, 4, number of DMA channels (1..8)
ADDRESS_WIDTH, 16, width of the base/current address registers (8..32)
COUNT_WIDTH, 16, width of the base/current word-count registers (8..32)

Ports:
clock  input  1  core clock; all state updates on its falling edge
reset  input  1  asynchronous, active-high reset
internal_data_bus  input  8  CPU write data
read_data  output  8  CPU read data, byte selected by byte_pointer
write_address  input  CHANNELS  one-hot, 1-cycle strobe: write one byte of base+current address
write_count  input  CHANNELS  one-hot, 1-cycle strobe: write one byte of base+current count
read_address  input  CHANNELS  one-hot level: select current address for reading
read_count  input  CHANNELS  one-hot level: select current count for reading
read_strobe  input  1  1-cycle pulse at the end of a CPU read; advances byte_pointer
clear_byte_pointer  input  1  software command
master_clear  input  1  software command
channel_select  input  CHANNELS  one-hot channel being serviced
initialize_current_register  input  1  copy base into current for channel_select
next_word  input  1  1-cycle pulse: step the selected channel
decrement_address_config  input  1  1 = address steps down
address_hold_config  input  1  1 = address does not step
autoinitialize_config  input  1  1 = reload from base on terminal count
byte_pointer  output  clog2(REG_BYTES) or 1  current byte index
transfer_address  output  ADDRESS_WIDTH  current address of the selected channel
terminal_count  output  1  1-cycle registered pulse on count underflow

Behaviour:
- REG_BYTES = ceil(max(ADDRESS_WIDTH, COUNT_WIDTH)/8). Byte k maps to bits [8k+7:8k]. On write, bits beyond a register's width are discarded. On read, they return 0.
- Reset and master_clear: all base/current registers 0, byte_pointer 0, terminal_count 0. read_data is 0 when no read select is active. transfer_address is 0 after reset.
- byte_pointer update priority: master_clear/clear_byte_pointer -> 0; else any write strobe or read_strobe -> +1, wrapping REG_BYTES-1 -> 0; else hold.
- CPU write: writes byte[byte_pointer] of both base and current registers of the strobed channel.
- Multiple bits in any one-hot input: the lowest index wins.
- Current-register update priority per channel: reset > master_clear > CPU write > initialize_current_register (channel selected) > next_word (channel selected) > hold.
- next_word on selected channel c:
  - tc_event = (current_count[c] == 0).
  - If tc_event and autoinitialize_config: current_address <= base_address and current_count <= base_count. No step occurs that cycle.
  - Otherwise, count <= count-1 modulo 2^COUNT_WIDTH, so 0 -> all-ones.
  - Address: unchanged if address_hold_config; else +/-1 modulo 2^ADDRESS_WIDTH.
- terminal_count: registered. It is 1 for exactly the one cycle following a next_word that had tc_event, and 0 otherwise.
- next_word with no channel selected: no state change, no terminal_count.
- transfer_address: combinational current_address of the channel_select channel. It is 0 if no channel is selected.
- Read mux: read_address has priority over read_count, lowest channel first. Output is byte[byte_pointer] of the selected current register.
- Base registers change only by CPU write or master_clear.
- Reset asserted mid-transfer: immediate clear, with no pending terminal_count.

Test Plan:
1. ADDRESS_WIDTH=24, COUNT_WIDTH=16, CHANNELS=6. clear_byte_pointer, then write_address[5] with 0x56, 0x34, 0x12 -> base and current address of ch5 = 0x123456, byte_pointer = 0. Three reads with read_strobe return 0x56, 0x34, 0x12.
2. ch2 count=0x0002, address=0x000010, increment, no autoinit. Three next_word pulses -> address 0x11, 0x12, 0x13; count 1, 0, 0xFFFF. terminal_count pulses only after the third.
3. Same setup with autoinitialize_config=1 -> third next_word reloads address 0x000010 and count 0x0002, with a terminal_count pulse. A fourth next_word gives 0x11/1.
4. Decrement from address 0x000000 -> 0xFFFFFF. With address_hold_config=1, next_word leaves the address unchanged and decrements the count.
5. CPU write_count[2] in the same cycle as next_word on ch2 -> the written byte wins and the count is not decremented. master_clear mid-sequence -> all registers and byte_pointer 0.
6. write_address = 6'b001010 -> only ch1 is written. A read with no select gives read_data 0.
